// File: rtl/iddmm_pkg.sv
// iddmm_pkg: shared defaults, address-width helper and FSM state encoding for the IDDMM blocks
package iddmm_pkg;
  localparam int K_DEF = 128;
  localparam int N_DEF = 32;
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  typedef enum logic [2:0] {IDLE, CMP, OUT, CLR, DONE} state_t;
endpackage

// File: rtl/iddmm_word_sub.sv
// iddmm_word_sub: K-bit subtract with borrow, {bout,diff} = a - b - bin
module iddmm_word_sub #(
  parameter int K = 128
) (
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  input  logic         bin,
  output logic [K-1:0] diff,
  output logic         bout
);
  assign {bout, diff} = {1'b0, a} - {1'b0, b} - (K+1)'(bin);
endmodule

// File: rtl/iddmm_cond_sub.sv
// iddmm_cond_sub: final R = ({an,A} >= M) ? A-M : A stage; define IDDMM_SUB_CLR_EN to zero the A RAM afterwards
module iddmm_cond_sub
  import iddmm_pkg::*;
#(
  parameter int K      = K_DEF,
  parameter int N      = N_DEF,
  parameter int ADDR_W = addr_w(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              task_req,
  output logic              task_end,
  output logic [K-1:0]      res,
  output logic              res_val,
  output logic              clra_mem,
  output logic              clra_wren,
  output logic [ADDR_W-1:0] clra_addr,
  input  logic [K-1:0]      aj,
  input  logic [K-1:0]      an,
  input  logic [K-1:0]      mj,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_m
);
  localparam logic [ADDR_W:0] CNT_N = (ADDR_W+1)'(N);
  state_t          state, state_nxt;
  logic [ADDR_W:0] cnt;
  logic            req_d, vld_d, borrow, use_sub, bout;
  logic            start, last, issue, out_v;
  logic [K-1:0]    diff;
  logic            unused_an;
  assign unused_an = ^an[K-1:1];
  assign start  = task_req & ~req_d;
  assign last   = (state == CLR) ? (cnt == CNT_N - 1'b1) : (cnt == CNT_N);
  assign issue  = (state == CMP || state == OUT) && cnt != CNT_N;
  assign out_v  = vld_d && state == OUT;
  assign addr_a = cnt[ADDR_W-1:0];
  assign addr_m = cnt[ADDR_W-1:0];
  assign task_end = state == DONE;
`ifdef IDDMM_SUB_CLR_EN
  assign clra_mem  = state == CLR;
  assign clra_wren = state == CLR;
  assign clra_addr = cnt[ADDR_W-1:0];
`else
  assign clra_mem  = 1'b0;
  assign clra_wren = 1'b0;
  assign clra_addr = '0;
`endif

  iddmm_word_sub #(.K(K)) u_sub (
    .a    (aj),
    .b    (mj),
    .bin  (borrow),
    .diff (diff),
    .bout (bout)
  );

  // next-state: each pass ends when its word counter reaches the pass length
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? CMP : IDLE;
      CMP:     state_nxt = last ? OUT : CMP;
`ifdef IDDMM_SUB_CLR_EN
      OUT:     state_nxt = last ? CLR : OUT;
      CLR:     state_nxt = last ? DONE : CLR;
`else
      OUT:     state_nxt = last ? DONE : OUT;
`endif
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // state register, start-edge detector and per-pass word counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      req_d <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      req_d <= task_req;
      cnt   <= (state_nxt != state || state == IDLE) ? '0 : cnt + 1'b1;
    end
  end

  // read data lags the address by one cycle; borrow chains across words, use_sub latched at compare exit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_d   <= 1'b0;
      borrow  <= 1'b0;
      use_sub <= 1'b0;
      res     <= '0;
      res_val <= 1'b0;
    end else begin
      vld_d   <= issue;
      borrow  <= (state == IDLE || (state == CMP && last)) ? 1'b0 : vld_d ? bout : borrow;
      use_sub <= (state == CMP && last) ? (an[0] | ~bout) : use_sub;
      res     <= out_v ? (use_sub ? diff : aj) : '0;
      res_val <= out_v;
    end
  end
endmodule

// File: tb/tb_iddmm_cond_sub.sv
// tb_iddmm_cond_sub: directed vectors for iddmm_cond_sub with K=8, N=4 and behavioural A/M RAMs
module tb_iddmm_cond_sub;
  localparam int K = 8;
  localparam int N = 4;
  localparam int AW = 2;
`ifdef IDDMM_SUB_CLR_EN
  localparam int LAT = 3*N+3;
`else
  localparam int LAT = 2*N+3;
`endif
  logic          clk = 1'b0, rst_n = 1'b0, task_req = 1'b0;
  logic          task_end, res_val, clra_mem, clra_wren;
  logic [K-1:0]  res, aj, mj, an;
  logic [AW-1:0] clra_addr, addr_a, addr_m;
  logic [K-1:0]  a_ram [N];
  logic [K-1:0]  m_ram [N];
  logic [31:0]   va [4], vm [4], vr [4];
  bit            van [4];
  int            n_cmp = 0, n_err = 0;

  iddmm_cond_sub #(.K(K), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .task_req(task_req), .task_end(task_end),
    .res(res), .res_val(res_val), .clra_mem(clra_mem), .clra_wren(clra_wren),
    .clra_addr(clra_addr), .aj(aj), .an(an), .mj(mj), .addr_a(addr_a), .addr_m(addr_m)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    aj <= a_ram[addr_a];
    mj <= m_ram[addr_m];
    if (clra_mem && clra_wren) a_ram[clra_addr] <= '0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input int t);
    for (int i = 0; i < N; i++) begin
      a_ram[i] = va[t][8*i +: 8];
      m_ram[i] = vm[t][8*i +: 8];
    end
    an = van[t] ? 8'hA1 : 8'hA0;
  endtask

  task automatic run_op(input int t, input bit hold);
    logic [31:0] r;
    int cyc, nv, nw, ev;
    r = '0; cyc = 0; nv = 0; nw = 0; ev = 0;
    load(t);
    task_req = 1'b1;
    while (cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (res_val) begin
        if (nv < N) r[8*nv +: 8] = res;
        nv++;
      end
      if (clra_wren) begin
        check($sformatf("t%0d clr_addr", t), 32'(clra_addr), 32'(nw));
        nw++;
      end
      if (task_end) break;
    end
    check($sformatf("t%0d latency", t), 32'(cyc), 32'(LAT));
    check($sformatf("t%0d res_val_count", t), 32'(nv), 32'(N));
    check($sformatf("t%0d result", t), r, vr[t]);
`ifdef IDDMM_SUB_CLR_EN
    check($sformatf("t%0d clr_writes", t), 32'(nw), 32'(N));
    check($sformatf("t%0d a_ram_cleared", t), {a_ram[3], a_ram[2], a_ram[1], a_ram[0]}, 32'h0);
`else
    check($sformatf("t%0d clr_writes", t), 32'(nw), 32'h0);
`endif
    if (hold) begin
      repeat (3*N+6) begin
        @(posedge clk); #1;
        ev += int'(res_val) + int'(task_end) + int'(addr_a != '0);
      end
      check($sformatf("t%0d no_restart", t), 32'(ev), 32'h0);
    end
    task_req = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int w;
    va  = '{32'h10000005, 32'h0F000001, 32'h01000000, 32'h78563412};
    vm  = '{32'h10000000, 32'h10000002, 32'hFF000001, 32'h78563412};
    vr  = '{32'h00000005, 32'h0F000001, 32'h01FFFFFF, 32'h00000000};
    van = '{1'b0, 1'b0, 1'b1, 1'b0};
    load(0);
    #12;
    check("rst res", 32'(res), 32'h0);
    check("rst res_val", 32'(res_val), 32'h0);
    check("rst task_end", 32'(task_end), 32'h0);
    check("rst clra", {30'h0, clra_mem, clra_wren}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int t = 0; t < 4; t++) run_op(t, 1'b0);
    load(0);
    task_req = 1'b1;
    w = 0;
    while (!res_val && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check("t6 reached_out", 32'(res_val), 32'h1);
    rst_n = 1'b0;
    #1;
    check("t6 rst res_val", 32'(res_val), 32'h0);
    check("t6 rst res", 32'(res), 32'h0);
    check("t6 rst task_end", 32'(task_end), 32'h0);
    check("t6 rst clra_mem", 32'(clra_mem), 32'h0);
    check("t6 rst addr_a", 32'(addr_a), 32'h0);
    task_req = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(2, 1'b1);
    run_op(0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
